// File: rtl/irq_ctrl.sv
// Interrupt controller: up to 16 sources with per-source edge/level trigger modes,
// pending/enable bits on the 8-bit CSR bus and one registered aggregated irq line.
module irq_ctrl #(
   parameter logic [4:0]  BASE_ADDR = 5'h1c,
   parameter int unsigned NUM_INTS  = 8,
   parameter bit          SYNC      = 1'b1,
   parameter logic [15:0] DFL_IE    = 16'h0000,
   parameter logic [15:0] DFL_TYPE  = 16'hffff,
   parameter logic [15:0] DFL_POL   = 16'h0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4:0]          csr_a,
   input  logic [7:0]          csr_di,
   input  logic                csr_we,
   output logic [7:0]          csr_do,
   input  logic [NUM_INTS-1:0] ints,
   output logic                irq
);

   localparam int unsigned NUM_BANKS = (NUM_INTS > 8) ? 2 : 1;
   localparam logic [15:0] VALID     = 16'((32'h1 << NUM_INTS) - 32'h1);

   logic [15:0] ie_q, ie_d, ip_q, ip_d, type_q, type_d, pol_q, pol_d, both_q, both_d;
   logic [15:0] w1c, x, prev_q, rise, fall, edge_trig, lvl_trig, trig, trig_q;
   logic [1:0]  arm_cnt_q;
   logic        armed;
   logic        irq_q;

   generate
      if (SYNC) begin : g_sync
         logic [NUM_INTS-1:0] s1_q, s2_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_q <= '0;
               s2_q <= '0;
            end else begin
               s1_q <= ints;
               s2_q <= s1_q;
            end
         end
         assign x = 16'(s2_q);
      end else begin : g_nosync
         assign x = 16'(ints);
      end
   endgenerate

   assign armed     = (arm_cnt_q == 2'd3);
   assign rise      = x & ~prev_q;
   assign fall      = ~x & prev_q;
   assign edge_trig = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
   assign lvl_trig  = ~(x ^ pol_q);
   assign trig      = ((type_q & edge_trig & {16{armed}}) | (~type_q & lvl_trig)) & VALID;

   // Register addresses wrap modulo 32, so high banks may alias down to low addresses.
   always_comb begin
      ie_d   = ie_q;
      type_d = type_q;
      pol_d  = pol_q;
      both_d = both_q;
      w1c    = '0;
      csr_do = 8'h00;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         for (int o = 0; o < 5; o++) begin
            if (csr_a == 5'(int'(BASE_ADDR) + 5 * b + o)) begin
               case (o)
                  0: begin
                     csr_do = ie_q[8*b +: 8];
                     if (csr_we) ie_d[8*b +: 8] = csr_di;
                  end
                  1: begin
                     csr_do = ip_q[8*b +: 8];
                     if (csr_we) w1c[8*b +: 8] = csr_di;
                  end
                  2: begin
                     csr_do = type_q[8*b +: 8];
                     if (csr_we) type_d[8*b +: 8] = csr_di;
                  end
                  3: begin
                     csr_do = pol_q[8*b +: 8];
                     if (csr_we) pol_d[8*b +: 8] = csr_di;
                  end
                  default: begin
                     csr_do = both_q[8*b +: 8];
                     if (csr_we) both_d[8*b +: 8] = csr_di;
                  end
               endcase
            end
         end
      end
      ie_d   = ie_d & VALID;
      type_d = type_d & VALID;
      pol_d  = pol_d & VALID;
      both_d = both_d & VALID;
      // Set wins over a simultaneous write-1-to-clear.
      ip_d   = ((ip_q & ~w1c) | trig_q) & VALID;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_q      <= DFL_IE & VALID;
         type_q    <= DFL_TYPE & VALID;
         pol_q     <= DFL_POL & VALID;
         both_q    <= '0;
         ip_q      <= '0;
         prev_q    <= '0;
         trig_q    <= '0;
         arm_cnt_q <= 2'd0;
         irq_q     <= 1'b0;
      end else begin
         ie_q      <= ie_d;
         type_q    <= type_d;
         pol_q     <= pol_d;
         both_q    <= both_d;
         ip_q      <= ip_d;
         prev_q    <= x;
         trig_q    <= trig;
         if (!armed) arm_cnt_q <= arm_cnt_q + 2'd1;
         irq_q     <= |(ip_q & ie_q);
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: an 8-source synchronised instance and a 12-source
// unsynchronised instance share one CSR bus; each has its own sources and outputs.
module tb_irq_ctrl;

   localparam logic [4:0] A_IE0 = 5'h1c, A_IP0 = 5'h1d, A_TYPE0 = 5'h1e, A_POL0 = 5'h1f;
   localparam logic [4:0] A_BOTH0 = 5'h00, A_IE1 = 5'h01, A_IP1 = 5'h02, A_TYPE1 = 5'h03;
   localparam logic [4:0] A_BOTH1 = 5'h05, A_NONE = 5'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  csr_a = '0;
   logic [7:0]  csr_di = '0;
   logic        csr_we = 1'b0;
   logic [7:0]  do0, do1;
   logic [7:0]  ints0 = '0;
   logic [11:0] ints1 = '0;
   logic        irq0, irq1;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   irq_ctrl #(.BASE_ADDR(5'h1c), .NUM_INTS(8), .SYNC(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
      .csr_do(do0), .ints(ints0), .irq(irq0)
   );

   irq_ctrl #(.BASE_ADDR(5'h1c), .NUM_INTS(12), .SYNC(1'b0), .DFL_POL(16'h0001)) dut1 (
      .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
      .csr_do(do1), .ints(ints1), .irq(irq1)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [4:0] a, input bit sel,
                         input logic [7:0] exp);
      csr_a = a;
      #1;
      check(tag, sel ? do1 : do0, exp);
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      @(negedge clk);
      csr_we = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_rd("rst_ie_in_reset", A_IE0, 0, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk_rd("rst_ie", A_IE0, 0, 8'h00);
      chk_rd("rst_ip", A_IP0, 0, 8'h00);
      chk_rd("rst_type", A_TYPE0, 0, 8'hff);
      chk_rd("rst_pol", A_POL0, 0, 8'h00);
      @(negedge clk);
      chk_rd("rst_both", A_BOTH0, 0, 8'h00);
      chk_rd("rst_unmapped0", A_NONE, 0, 8'h00);
      check("rst_irq", {7'b0, irq0}, 8'h00);
      @(negedge clk);
      chk_rd("rst_type_bank1", A_TYPE1, 1, 8'h0f);
      chk_rd("rst_unmapped1", A_NONE, 1, 8'h00);
      repeat (3) @(negedge clk);

      // Rising edge on source 0, synchronised path
      csr_wr(A_POL0, 8'h01);
      csr_wr(A_IE0, 8'h01);
      ints0[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk_rd("rise_ip_k2", A_IP0, 0, 8'h00);
      @(negedge clk);
      chk_rd("rise_ip_k3", A_IP0, 0, 8'h01);
      check("rise_irq_k3", {7'b0, irq0}, 8'h00);
      @(negedge clk);
      check("rise_irq_k4", {7'b0, irq0}, 8'h01);
      csr_wr(A_IP0, 8'h01);
      chk_rd("rise_ip_cleared", A_IP0, 0, 8'h00);
      check("rise_irq_w", {7'b0, irq0}, 8'h01);
      @(negedge clk);
      check("rise_irq_w1", {7'b0, irq0}, 8'h00);
      ints0[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk_rd("rise_ignores_fall", A_IP0, 0, 8'h00);

      // Both edges on source 9 (bank 1), unsynchronised path
      csr_wr(A_BOTH1, 8'h02);
      csr_wr(A_IE1, 8'h02);
      ints1[9] = 1'b1;
      @(negedge clk);
      chk_rd("both_ip_k0", A_IP1, 1, 8'h00);
      @(negedge clk);
      chk_rd("both_ip_k1", A_IP1, 1, 8'h02);
      @(negedge clk);
      check("both_irq_k2", {7'b0, irq1}, 8'h01);
      csr_wr(A_IP1, 8'h02);
      chk_rd("both_ip_cleared", A_IP1, 1, 8'h00);
      repeat (6) @(negedge clk);
      ints1[9] = 1'b0;
      @(negedge clk);
      chk_rd("both_fall_k0", A_IP1, 1, 8'h00);
      @(negedge clk);
      chk_rd("both_fall_k1", A_IP1, 1, 8'h02);

      // Level-low on source 3; the other sources are level-high and idle low
      csr_wr(A_POL0, 8'hf7);
      csr_wr(A_TYPE0, 8'h00);
      csr_wr(A_IE0, 8'h08);
      repeat (3) @(negedge clk);
      chk_rd("lvl_ip_set", A_IP0, 0, 8'h08);
      check("lvl_irq_set", {7'b0, irq0}, 8'h01);
      csr_wr(A_IP0, 8'h08);
      chk_rd("lvl_no_clear", A_IP0, 0, 8'h08);
      ints0[3] = 1'b1;
      repeat (4) @(negedge clk);
      csr_wr(A_IP0, 8'h08);
      chk_rd("lvl_cleared", A_IP0, 0, 8'h00);
      @(negedge clk);
      chk_rd("lvl_ip_stays_clear", A_IP0, 0, 8'h00);
      check("lvl_irq_dropped", {7'b0, irq0}, 8'h00);

      // Set/clear collision on source 2
      csr_wr(A_TYPE0, 8'hff);
      repeat (3) @(negedge clk);
      csr_wr(A_IP0, 8'hff);
      ints0[2] = 1'b1;
      repeat (3) @(negedge clk);
      chk_rd("coll_ip_before", A_IP0, 0, 8'h00);
      csr_wr(A_IP0, 8'h04);
      chk_rd("coll_set_wins", A_IP0, 0, 8'h04);

      // Masking: falling edge on source 3 with IE cleared
      csr_wr(A_IE0, 8'h00);
      csr_wr(A_IP0, 8'hff);
      ints0[3] = 1'b0;
      repeat (5) @(negedge clk);
      chk_rd("mask_ip_set", A_IP0, 0, 8'h08);
      check("mask_irq_low", {7'b0, irq0}, 8'h00);
      csr_wr(A_IE0, 8'hff);
      check("mask_irq_w", {7'b0, irq0}, 8'h00);
      @(negedge clk);
      check("mask_irq_w1", {7'b0, irq0}, 8'h01);

      // Asynchronous reset while irq is high; source 0 of dut1 held high throughout
      ints1[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_irq", {7'b0, irq0}, 8'h00);
      chk_rd("arst_ip", A_IP0, 0, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_rd("arm_no_false_edge", A_IP0, 1, 8'h00);
      ints1[0] = 1'b0;
      @(negedge clk);
      ints1[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk_rd("arm_real_edge", A_IP0, 1, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
